// File: rtl/axi_llc_data_rsp_buf.sv
// rtl/axi_llc_data_rsp_buf.sv - SRAM read-response buffer with credit-gated request acceptance
// Optional feature macro AXI_LLC_DATA_RSP_BUF_WR_ACK_EN: writes take a credit and return an ack entry.
module axi_llc_data_rsp_buf #(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter int FifoDepth = 2,
  localparam int BeWidth  = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  output logic [BeWidth-1:0]   ram_be_o,
  input  logic [DataWidth-1:0] ram_rdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_wr_o
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);

  if (FifoDepth < 1) begin : g_depth_chk
    $error("FifoDepth must be at least 1");
  end
  if (Latency < 1) begin : g_lat_chk
    $error("Latency must be at least 1");
  end

  logic                 has_credit;
  logic                 req_fire;
  logic                 consume;
  logic                 wr_tag;
  logic                 push;
  logic                 pop;
  logic [DataWidth-1:0] push_data;
  logic                 push_wr;

  logic [Latency-1:0]   vld_q, vld_d;
  logic [Latency-1:0]   wtag_q, wtag_d;
  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      credit_q, credit_d;
  logic [DataWidth-1:0] data_mem_q [FifoDepth];
  logic [FifoDepth-1:0] wr_mem_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Readiness looks only at the registered credit count, never at rsp_ready_i.
  assign has_credit = (credit_q != '0);

`ifdef AXI_LLC_DATA_RSP_BUF_WR_ACK_EN
  assign req_ready_o = rst_ni & has_credit;
  assign consume     = req_fire;
  assign wr_tag      = req_we_i;
`else
  assign req_ready_o = rst_ni & (req_we_i | has_credit);
  assign consume     = req_fire & ~req_we_i;
  assign wr_tag      = 1'b0;
`endif

  assign req_fire    = req_valid_i & req_ready_o;
  assign ram_req_o   = req_fire;
  assign ram_we_o    = req_we_i;
  assign ram_addr_o  = req_addr_i;
  assign ram_wdata_o = req_wdata_i;
  assign ram_be_o    = req_be_i;

  assign push      = vld_q[Latency-1];
  assign push_wr   = wtag_q[Latency-1];
  assign push_data = push_wr ? '0 : ram_rdata_i;

  assign rsp_valid_o = rst_ni & (count_q != '0);
  assign rsp_rdata_o = data_mem_q[rptr_q];
  assign rsp_wr_o    = rsp_valid_o & wr_mem_q[rptr_q];
  assign pop         = rsp_valid_o & rsp_ready_i;

  always_comb begin
    vld_d     = '0;
    wtag_d    = '0;
    vld_d[0]  = consume;
    wtag_d[0] = wr_tag;
    for (int i = 1; i < Latency; i++) begin
      vld_d[i]  = vld_q[i-1];
      wtag_d[i] = wtag_q[i-1];
    end
  end

  always_comb begin
    wptr_d   = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d   = pop ? ptr_inc(rptr_q) : rptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    credit_d = credit_q - CntW'(consume) + CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q    <= '0;
      wtag_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      credit_q <= CntW'(FifoDepth);
    end else begin
      vld_q    <= vld_d;
      wtag_q   <= wtag_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count_q covers it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[wptr_q] <= push_data;
      wr_mem_q[wptr_q]   <= push_wr;
    end
  end

endmodule

// File: tb/tb_axi_llc_data_rsp_buf.sv
// tb/tb_axi_llc_data_rsp_buf.sv - self-checking bench for axi_llc_data_rsp_buf
module tb_axi_llc_data_rsp_buf;
  localparam int AW = 10;
  localparam int DW = 128;
  localparam int BW = 16;
`ifdef AXI_LLC_DATA_RSP_BUF_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 16) ? DW'(32'hDEAD) : DW'(i);
  endfunction

  typedef struct packed { logic wr; logic [DW-1:0] data; } rsp_t;

  // DUT A: Latency 1, depth 2
  logic          a_rst_n, a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr, a_ram_addr;
  logic [DW-1:0] a_req_wdata, a_ram_wdata, a_ram_rdata, a_rsp_rdata;
  logic [BW-1:0] a_req_be, a_ram_be;
  logic          a_ram_req, a_ram_we, a_rsp_valid, a_rsp_ready, a_rsp_wr;

  axi_llc_data_rsp_buf #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .Latency(1), .FifoDepth(2)) u_a (
    .clk_i(clk), .rst_ni(a_rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
    .ram_req_o(a_ram_req), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr),
    .ram_wdata_o(a_ram_wdata), .ram_be_o(a_ram_be), .ram_rdata_i(a_ram_rdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata), .rsp_wr_o(a_rsp_wr)
  );

  // DUT B: Latency 2; depth 4 covers the pipeline plus the cycle a popped credit takes to return
  logic          b_rst_n, b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] b_req_addr, b_ram_addr;
  logic [DW-1:0] b_req_wdata, b_ram_wdata, b_ram_rdata, b_rsp_rdata;
  logic [BW-1:0] b_req_be, b_ram_be;
  logic          b_ram_req, b_ram_we, b_rsp_valid, b_rsp_ready, b_rsp_wr;

  axi_llc_data_rsp_buf #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .Latency(2), .FifoDepth(4)) u_b (
    .clk_i(clk), .rst_ni(b_rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .ram_req_o(b_ram_req), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_be_o(b_ram_be), .ram_rdata_i(b_ram_rdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata), .rsp_wr_o(b_rsp_wr)
  );

  // SRAM models
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] rd_a;
  always @(posedge clk) begin
    if (!a_rst_n) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= init_word(i);
    end else if (a_ram_req) begin
      if (a_ram_we) begin
        for (int b = 0; b < BW; b++)
          if (a_ram_be[b]) mem_a[a_ram_addr][8*b +: 8] <= a_ram_wdata[8*b +: 8];
      end else begin
        rd_a <= mem_a[a_ram_addr];
      end
    end
  end
  assign a_ram_rdata = rd_a;

  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] rd_b0, rd_b1;
  always @(posedge clk) begin
    if (!b_rst_n) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= init_word(i);
    end else begin
      if (b_ram_req && !b_ram_we) rd_b0 <= mem_b[b_ram_addr];
      rd_b1 <= rd_b0;
    end
  end
  assign b_ram_rdata = rd_b1;

  // Scoreboard A: expected responses pushed on accept, popped on response
  rsp_t          q_a [$];
  logic [DW-1:0] sh_a [1024];
  logic          hold_a = 1'b0;
  logic [DW-1:0] hold_data_a;
  always @(negedge clk) begin
    rsp_t e;
    if (!a_rst_n) begin
      q_a.delete();
      hold_a = 1'b0;
      for (int i = 0; i < 1024; i++) sh_a[i] = init_word(i);
    end else begin
      if (hold_a) begin
        chk("a_hold_valid", DW'(a_rsp_valid), DW'(1));
        chk("a_hold_data", a_rsp_rdata, hold_data_a);
      end
      hold_a      = a_rsp_valid && !a_rsp_ready;
      hold_data_a = a_rsp_rdata;
      if (a_req_valid && a_req_ready) begin
        if (!a_req_we) begin
          e.wr = 1'b0; e.data = sh_a[a_req_addr];
          q_a.push_back(e);
        end else begin
          for (int b = 0; b < BW; b++)
            if (a_req_be[b]) sh_a[a_req_addr][8*b +: 8] = a_req_wdata[8*b +: 8];
          if (WR_ACK) begin
            e.wr = 1'b1; e.data = '0;
            q_a.push_back(e);
          end
        end
      end
      if (a_rsp_valid && a_rsp_ready) begin
        chk("a_rsp_pending", DW'(q_a.size() != 0), DW'(1));
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          chk("a_rsp_rdata", a_rsp_rdata, e.data);
          chk("a_rsp_wr", DW'(a_rsp_wr), DW'(e.wr));
        end
      end
    end
  end

  // Scoreboard B with response timing
  rsp_t q_b [$];
  int   nrsp_b = 0;
  int   first_b = 0;
  int   last_b = 0;
  always @(negedge clk) begin
    rsp_t e;
    if (!b_rst_n) begin
      q_b.delete();
    end else begin
      if (b_req_valid && b_req_ready && !b_req_we) begin
        e.wr = 1'b0; e.data = init_word(int'(b_req_addr));
        q_b.push_back(e);
      end
      if (b_rsp_valid && b_rsp_ready) begin
        chk("b_rsp_pending", DW'(q_b.size() != 0), DW'(1));
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          chk("b_rsp_rdata", b_rsp_rdata, e.data);
          chk("b_rsp_wr", DW'(b_rsp_wr), DW'(e.wr));
        end
        if (nrsp_b == 0) first_b = cyc;
        last_b = cyc;
        nrsp_b++;
      end
    end
  end

  typedef struct {
    logic v; logic we; logic [AW-1:0] addr; logic [DW-1:0] wd; logic rr;
    logic e_rdy; logic e_req; logic e_we; logic e_rspv;
  } vec_t;
  vec_t tbl [18];

  function automatic vec_t mk(input logic v, we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic rr, rdy, req, wen, rspv);
    vec_t t;
    t.v = v; t.we = we; t.addr = addr; t.wd = wd; t.rr = rr;
    t.e_rdy = rdy; t.e_req = req; t.e_we = wen; t.e_rspv = rspv;
    return t;
  endfunction

  task automatic drv_a(input logic v, we, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic rr);
    a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_rsp_ready = rr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic rdy, req, rspv);
    @(negedge clk);
    chk({tag, "_ready"}, DW'(a_req_ready), DW'(rdy));
    chk({tag, "_ram_req"}, DW'(a_ram_req), DW'(req));
    chk({tag, "_rsp_valid"}, DW'(a_rsp_valid), DW'(rspv));
  endtask

  int issued, lows, guard;

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    drv_a(1'b1, 1'b0, 10'h010, '0, 1'b1);
    a_req_be = '1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '1; b_rsp_ready = 1'b1;

    tbl[0]  = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 10'h010, '0, 1, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 10'h001, '0, 0, 1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 10'h002, '0, 0, 1, 1, 0, 0);
    tbl[7]  = mk(1, 0, 10'h003, '0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 0, 10'h003, '0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 1, 10'h004, DW'(32'hBEEF), 0, !WR_ACK, !WR_ACK, 1, 1);
    tbl[10] = mk(1, 0, 10'h003, '0, 1, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 10'h003, '0, 1, 1, 1, 0, 1);
    tbl[12] = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 0);
    tbl[13] = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 1);
    tbl[14] = mk(1, 0, 10'h004, '0, 1, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 1);
    tbl[17] = mk(0, 0, 10'h000, '0, 1, 1, 0, 0, 0);

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", DW'(a_req_ready), DW'(0));
      chk("rst_ram_req", DW'(a_ram_req), DW'(0));
      chk("rst_rsp_valid", DW'(a_rsp_valid), DW'(0));
      chk("rst_rsp_wr", DW'(a_rsp_wr), DW'(0));
    end
    step;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drv_a(tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rr);
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), DW'(a_req_ready), DW'(tbl[i].e_rdy));
      chk($sformatf("row%0d_ram_req", i), DW'(a_ram_req), DW'(tbl[i].e_req));
      chk($sformatf("row%0d_ram_we", i), DW'(a_ram_we), DW'(tbl[i].e_we));
      chk($sformatf("row%0d_rsp_valid", i), DW'(a_rsp_valid), DW'(tbl[i].e_rspv));
      if (tbl[i].v) chk($sformatf("row%0d_ram_addr", i), DW'(a_ram_addr), DW'(tbl[i].addr));
      step;
    end

    // Reset with two reads outstanding
    drv_a(1, 0, 10'h005, '0, 0); exp_a("mid_rd5", 1, 1, 0); step;
    drv_a(1, 0, 10'h006, '0, 0); exp_a("mid_rd6", 1, 1, 0); step;
    a_rst_n = 1'b0; drv_a(0, 0, 10'h000, '0, 0); exp_a("mid_rst", 0, 0, 0); step;
    a_rst_n = 1'b1; drv_a(0, 0, 10'h000, '0, 1); exp_a("post_rst", 1, 0, 0); step;
    repeat (3) begin exp_a("post_rst_idle", 1, 0, 0); step; end
    drv_a(1, 0, 10'h007, '0, 0); exp_a("cred_rd7", 1, 1, 0); step;
    drv_a(1, 0, 10'h008, '0, 0); exp_a("cred_rd8", 1, 1, 0); step;
    drv_a(1, 0, 10'h009, '0, 0); exp_a("cred_rd9", 0, 0, 1); step;
    drv_a(0, 0, 10'h000, '0, 1);
    repeat (4) step;

    // Write then read of the same word
    drv_a(1, 1, 10'h005, DW'(32'hCAFE), 1); exp_a("wr5", 1, 1, 0); step;
    drv_a(1, 0, 10'h005, '0, 1); exp_a("rd5", 1, 1, 0); step;
    drv_a(0, 0, 10'h000, '0, 1); exp_a("wr5_ack", 1, 0, WR_ACK); step;
    exp_a("rd5_rsp", 1, 0, 1); step;
    exp_a("rd5_done", 1, 0, 0); step;
    chk("a_q_empty", DW'(q_a.size()), DW'(0));

    // Back-to-back reads on DUT B
    issued = 0; lows = 0; guard = 0;
    b_req_valid = 1'b1; b_req_addr = 10'h020;
    while (issued < 16 && guard < 100) begin
      @(negedge clk);
      if (b_req_ready) issued++;
      else lows++;
      guard++;
      step;
      b_req_addr  = AW'(32 + issued);
      b_req_valid = (issued < 16);
    end
    chk("b_issued", DW'(issued), DW'(16));
    chk("b_ready_lows", DW'(lows), DW'(0));
    guard = 0;
    while (nrsp_b < 16 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    chk("b_nrsp", DW'(nrsp_b), DW'(16));
    chk("b_span", DW'(last_b - first_b), DW'(15));
    chk("b_q_empty", DW'(q_b.size()), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
